// File: rtl/traffic_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// traffic_pkg : light encodings and timer width shared with the FSM
// Revision    : 1.0
// ------------------------------------------------------------------
package traffic_pkg;

   localparam logic [2:0] LIGHT_GREEN  = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_RED    = 3'b001;

   localparam int TW = 6;

   typedef logic [TW-1:0] timer_t;

   // A countdown rests at 1 (and 0 stays 0) until the next reload.
   function automatic timer_t sat_dec(input timer_t v);
      return (v > timer_t'(1)) ? v - timer_t'(1) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ------------------------------------------------------------------
// tick_prescaler : divides clk down to a 1-cycle pulse every CLK_PER_SEC
// Revision       : 1.0
// ------------------------------------------------------------------
module tick_prescaler #(
   parameter int unsigned CLK_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

   if (CLK_PER_SEC < 1) begin : g_bad_cps
      $error("tick_prescaler: CLK_PER_SEC must be >= 1");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic          wrap;

   assign wrap = (cnt_q == LAST);

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d  = '0;
      end else begin
         tick_d = wrap;
         cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/light_phase_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// light_phase_timer : per-second green/yellow countdowns for the light FSM
// Revision          : 1.0
// ------------------------------------------------------------------
module light_phase_timer
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_PER_SEC = 50_000_000,
   parameter int unsigned GREEN_SEC   = 30,
   parameter int unsigned YELLOW_SEC  = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [2:0]    light,
   output logic [TW-1:0] green_time,
   output logic [TW-1:0] yellow_time,
   output logic          tick,
   output logic          start_err
);

   if (GREEN_SEC < 2 || GREEN_SEC > 63) begin : g_bad_green
      $error("light_phase_timer: GREEN_SEC must be in 2..63");
   end
   if (YELLOW_SEC < 2 || YELLOW_SEC > 63) begin : g_bad_yellow
      $error("light_phase_timer: YELLOW_SEC must be in 2..63");
   end

   localparam timer_t GREEN_LOAD  = timer_t'(GREEN_SEC);
   localparam timer_t YELLOW_LOAD = timer_t'(YELLOW_SEC);

   timer_t green_q,  green_d;
   timer_t yellow_q, yellow_d;
   logic   err_q,    err_d;
   logic   tick_w;

   // Every start, valid or not, realigns the one-second grid.
   tick_prescaler #(
      .CLK_PER_SEC (CLK_PER_SEC)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .tick  (tick_w)
   );

   always_comb begin
      green_d  = green_q;
      yellow_d = yellow_q;
      err_d    = 1'b0;
      if (start) begin
         case (light)
            LIGHT_GREEN: begin
               yellow_d = YELLOW_LOAD;
               green_d  = '0;
            end
            LIGHT_RED: begin
               green_d  = GREEN_LOAD;
               yellow_d = '0;
            end
            default: err_d = 1'b1;
         endcase
      end else if (tick_w) begin
         green_d  = sat_dec(green_q);
         yellow_d = sat_dec(yellow_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         green_q  <= GREEN_LOAD;
         yellow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         green_q  <= green_d;
         yellow_q <= yellow_d;
         err_q    <= err_d;
      end
   end

   assign green_time  = green_q;
   assign yellow_time = yellow_q;
   assign tick        = tick_w;
   assign start_err   = err_q;

endmodule
`default_nettype wire
